// File: rtl/sisc_mem_arb.sv
// rtl/sisc_mem_arb.sv - two-port fetch/data arbiter and fixed-latency access sequencer
// Data wins ties; starve_cnt forces a pending fetch through after STARVE_MAX data grants.
module sisc_mem_arb #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state_q;
  logic [2:0]    lat_cnt_q;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          gnt_data_q, gnt_data_d;
  logic          f_ack_q, d_ack_q, mem_en_q, mem_we_q, busy_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, f_rdata_q, d_rdata_q;

  // Grant choice and starvation update, applied only on an IDLE edge with a request.
  always_comb begin
    gnt_data_d   = d_req && !(f_req && (starve_cnt_q == STARVE_LIM));
    starve_cnt_d = 4'd0;
    if (gnt_data_d && f_req) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
      gnt_data_q   <= 1'b0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (f_req || d_req) begin
            state_q      <= ACCESS;
            busy_q       <= 1'b1;
            mem_en_q     <= 1'b1;
            lat_cnt_q    <= LAT_INIT;
            gnt_data_q   <= gnt_data_d;
            starve_cnt_q <= starve_cnt_d;
            if (gnt_data_d) begin
              mem_addr_q  <= d_addr;
              mem_we_q    <= d_we;
              mem_wdata_q <= d_wdata;
            end else begin
              mem_addr_q <= f_addr;
              mem_we_q   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (lat_cnt_q == 3'd0) begin
            state_q  <= DONE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (gnt_data_q) begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              f_ack_q   <= 1'b1;
              f_rdata_q <= mem_rdata;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          f_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sisc_mem_arb.sv
// tb/tb_sisc_mem_arb.sv - self-checking bench for sisc_mem_arb
// Directed cycle table, starvation and reset-abort sequences, then random traffic vs a timeline model.
module tb_sisc_mem_arb;

  localparam int LAT = 3;
  localparam int SM  = 3;
  localparam int NV  = 21;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;
  logic        f_ack, d_ack, mem_en, mem_we, busy;
  logic [31:0] f_rdata, d_rdata, mem_wdata;
  logic [15:0] mem_addr;

  int checks = 0;
  int failures = 0;

  sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_f(rst_f),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f_req;
    logic [15:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic        e_en;
    logic        e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wd;
    logic        e_fack;
    logic        e_dack;
    logic [31:0] e_frd;
    logic [31:0] e_drd;
    logic        e_busy;
  } vec_t;

  vec_t tbl[NV];

  function automatic vec_t mk(input logic fr, input logic [15:0] fa, input logic dr,
                              input logic dwe, input logic [15:0] da, input logic [31:0] dwd,
                              input logic [31:0] mrd, input logic een, input logic ewe,
                              input logic [15:0] eaddr, input logic [31:0] ewd,
                              input logic efack, input logic edack, input logic [31:0] efrd,
                              input logic [31:0] edrd, input logic ebusy);
    vec_t v;
    v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dwe; v.d_addr = da;
    v.d_wdata = dwd; v.mem_rdata = mrd; v.e_en = een; v.e_we = ewe; v.e_addr = eaddr;
    v.e_wd = ewd; v.e_fack = efack; v.e_dack = edack; v.e_frd = efrd; v.e_drd = edrd;
    v.e_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_en, input logic e_we,
                           input logic [15:0] e_addr, input logic [31:0] e_wd,
                           input logic e_fack, input logic e_dack, input logic [31:0] e_frd,
                           input logic [31:0] e_drd, input logic e_busy);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'(e_en));
    chk({tag, "_mem_we"}, 32'(mem_we), 32'(e_we));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(e_addr));
    if (e_we) chk({tag, "_mem_wdata"}, mem_wdata, e_wd);
    chk({tag, "_f_ack"}, 32'(f_ack), 32'(e_fack));
    chk({tag, "_d_ack"}, 32'(d_ack), 32'(e_dack));
    chk({tag, "_f_rdata"}, f_rdata, e_frd);
    chk({tag, "_d_rdata"}, d_rdata, e_drd);
    chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_f = 1'b0;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_f = 1'b1;
  endtask

  // Random-phase timeline model state
  logic        cur_v, cur_d, cur_we, take_d, in_acc, done_c;
  int          cur_start, m_starve, n;
  logic [15:0] cur_addr, m_addr;
  logic [31:0] cur_wd, cur_cap, m_wd, m_frd, m_drd;
  logic        seen;
  string       got, exp_s;

  initial begin
    // Fetch with address change after grant, store, then simultaneous load+fetch (MEM_LAT=3)
    tbl[0]  = mk(1, 16'h0005, 0, 0, 0, 0, 0,            0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 16'h0099, 0, 0, 0, 0, 0,            1, 0, 16'h0005, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 16'h0099, 0, 0, 0, 0, 0,            1, 0, 16'h0005, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 16'h0099, 0, 0, 0, 0, 32'h12345678, 1, 0, 16'h0005, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,                   0, 0, 16'h0005, 0, 1, 0, 32'h12345678, 0, 1);
    tbl[5]  = mk(0, 0, 1, 1, 16'h0020, 32'hDEADBEEF, 32'hAAAAAAAA,
                 0, 0, 16'h0005, 0, 0, 0, 32'h12345678, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 32'hBBBBBBBB,
                 1, 1, 16'h0020, 32'hDEADBEEF, 0, 0, 32'h12345678, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 32'hBBBBBBBB,
                 1, 1, 16'h0020, 32'hDEADBEEF, 0, 0, 32'h12345678, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 32'hCCCCCCCC,
                 1, 1, 16'h0020, 32'hDEADBEEF, 0, 0, 32'h12345678, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0020, 0, 0, 1, 32'h12345678, 0, 1);
    tbl[10] = mk(1, 16'h0011, 1, 0, 16'h0040, 0, 0, 0, 0, 16'h0020, 0, 0, 0, 32'h12345678, 0, 0);
    tbl[11] = mk(1, 16'h0011, 0, 0, 0, 0, 0, 1, 0, 16'h0040, 0, 0, 0, 32'h12345678, 0, 1);
    tbl[12] = mk(1, 16'h0011, 0, 0, 0, 0, 0, 1, 0, 16'h0040, 0, 0, 0, 32'h12345678, 0, 1);
    tbl[13] = mk(1, 16'h0011, 0, 0, 0, 0, 32'hCAFEF00D,
                 1, 0, 16'h0040, 0, 0, 0, 32'h12345678, 0, 1);
    tbl[14] = mk(1, 16'h0011, 0, 0, 0, 0, 0,
                 0, 0, 16'h0040, 0, 0, 1, 32'h12345678, 32'hCAFEF00D, 1);
    tbl[15] = mk(1, 16'h0011, 0, 0, 0, 0, 0,
                 0, 0, 16'h0040, 0, 0, 0, 32'h12345678, 32'hCAFEF00D, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0011, 0, 0, 0, 32'h12345678, 32'hCAFEF00D, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0011, 0, 0, 0, 32'h12345678, 32'hCAFEF00D, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 32'h0BADC0DE,
                 1, 0, 16'h0011, 0, 0, 0, 32'h12345678, 32'hCAFEF00D, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0011, 0, 1, 0, 32'h0BADC0DE, 32'hCAFEF00D, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0011, 0, 0, 0, 32'h0BADC0DE, 32'hCAFEF00D, 0);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      check_all($sformatf("tbl%0d", i), tbl[i].e_en, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wd,
                tbl[i].e_fack, tbl[i].e_dack, tbl[i].e_frd, tbl[i].e_drd, tbl[i].e_busy);
      f_req = tbl[i].f_req; f_addr = tbl[i].f_addr; d_req = tbl[i].d_req;
      d_we = tbl[i].d_we; d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
      mem_rdata = tbl[i].mem_rdata;
      step();
    end

    // Both requests held: grant order must be D,D,D,F,D,D,D,F
    do_reset();
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 16'h0100; d_addr = 16'h0200;
    got = ""; exp_s = "DDDFDDDF"; n = 0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      step();
      if (d_ack) begin got = {got, "D"}; n++; end
      if (f_ack) begin got = {got, "F"}; n++; end
    end
    f_req = 1'b0; d_req = 1'b0;
    chk("starve_grant_count", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("starve_grant%0d", i), (i < got.len()) ? 32'(got[i]) : 32'd0, 32'(exp_s[i]));
    end

    // Reset asserted mid-access aborts the transaction without an ack
    do_reset();
    f_req = 1'b1; f_addr = 16'h0033;
    step();
    f_req = 1'b0;
    step();
    chk("rst_mid_en_before", 32'(mem_en), 32'd1);
    #3;
    rst_f = 1'b0;
    #1;
    chk("rst_mid_en", 32'(mem_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst_f = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | f_ack | d_ack | mem_en | busy;
      step();
    end
    chk("rst_no_ack_after", 32'(seen), 32'd0);
    f_req = 1'b1; f_addr = 16'h0077; mem_rdata = 32'h5A5A5A5A;
    step();
    f_req = 1'b0;
    repeat (LAT) step();
    chk("rst_refetch_ack", 32'(f_ack), 32'd1);
    chk("rst_refetch_rdata", f_rdata, 32'h5A5A5A5A);
    step();
    chk("rst_refetch_idle", 32'(busy), 32'd0);

    // Random traffic against a transaction-timeline model
    do_reset();
    cur_v = 1'b0; cur_d = 1'b0; cur_we = 1'b0; cur_start = 0; m_starve = 0;
    cur_addr = '0; cur_wd = '0; cur_cap = '0;
    m_addr = '0; m_wd = '0; m_frd = '0; m_drd = '0;
    for (int c = 0; c < 600; c++) begin
      if (cur_v && c == cur_start + 1) begin
        m_addr = cur_addr;
        if (cur_d) m_wd = cur_wd;
      end
      if (cur_v && c == cur_start + LAT + 1 && !cur_we) begin
        if (cur_d) m_drd = cur_cap;
        else m_frd = cur_cap;
      end
      in_acc = cur_v && (c >= cur_start + 1) && (c <= cur_start + LAT);
      done_c = cur_v && (c == cur_start + LAT + 1);
      check_all("rnd", in_acc, in_acc && cur_we, m_addr, m_wd, done_c && !cur_d,
                done_c && cur_d, m_frd, m_drd, in_acc || done_c);

      f_req = ($urandom_range(0, 3) != 0);
      d_req = ($urandom_range(0, 3) != 0);
      d_we = 1'($urandom_range(0, 1));
      f_addr = 16'($urandom);
      d_addr = 16'($urandom);
      d_wdata = $urandom;
      mem_rdata = $urandom;
      if (cur_v && c == cur_start + LAT) cur_cap = mem_rdata;

      if ((!cur_v || c >= cur_start + LAT + 2) && (f_req || d_req)) begin
        take_d = d_req && !(f_req && m_starve == SM);
        if (take_d) begin
          m_starve = f_req ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
          cur_d = 1'b1; cur_we = d_we; cur_addr = d_addr; cur_wd = d_wdata;
        end else begin
          m_starve = 0;
          cur_d = 1'b0; cur_we = 1'b0; cur_addr = f_addr;
        end
        cur_v = 1'b1;
        cur_start = c;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sisc_mem_arb.md
# sisc_mem_arb

Two-port arbiter and access sequencer for the SISC single-ported unified memory. It serves the instruction-fetch path (PC/IR side, read-only) and the data load/store path (register file/ALU side), one transaction at a time. Each transaction holds a stable address for a fixed memory latency and returns a one-cycle acknowledge with registered read data. Data accesses have priority over fetches, and a starvation counter bounds how long a pending fetch can be deferred.

## Interface
- AW, 16, address width
- DW, 32, data width (instruction and data words)
- MEM_LAT, 1, memory access cycles per transaction; legal range 1..8
- STARVE_MAX, 3, consecutive data grants allowed while a fetch is pending; legal range 1..15
- clk  in  1  system clock; all state updates on the rising edge
- rst_f  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request
- f_addr  in  AW  fetch address
- f_ack  out  1  fetch done pulse (one cycle)
- f_rdata  out  DW  fetched word, valid while f_ack=1, held afterwards
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  data done pulse (one cycle)
- d_rdata  out  DW  load word, valid while d_ack=1, held afterwards
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid on the last mem_en cycle
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states and transitions:
  - IDLE: at each rising edge, sample f_req and d_req. If either is high, grant one, latch its address, we and wdata, and go to ACCESS with lat_cnt = MEM_LAT-1. If neither is high, stay in IDLE.
  - ACCESS: mem_en=1. mem_we=1 only for a granted store. mem_addr and mem_wdata are driven from the latched values. Decrement lat_cnt each cycle. At the edge where lat_cnt=0, capture mem_rdata into the granted port's rdata register (loads and fetches only), then go to DONE.
  - DONE: pulse the granted port's ack for exactly one cycle, then go to IDLE. Requests are not sampled in DONE.
- Grant priority when both requests are high at an IDLE edge:
  - Data wins, unless starve_cnt == STARVE_MAX; in that case fetch wins.
- starve_cnt (4 bits) updates at each grant:
  - Data granted while f_req=1: starve_cnt+1, saturating at STARVE_MAX.
  - Fetch granted: cleared to 0.
  - Data granted while f_req=0: cleared to 0.
- Request semantics:
  - A request is a req level seen high at an IDLE sampling edge. Each ack consumes one request.
  - A requester that holds req high through the IDLE cycle after its ack issues a new request, using its address at that time.
  - addr, we and wdata are latched at grant; later input changes do not affect the transaction in flight.
- Fetch never writes. Stores leave d_rdata unchanged. The ungranted port's ack and rdata are unchanged.
- mem_addr and mem_wdata hold their last values in IDLE and DONE. mem_en=mem_we=0 outside ACCESS.

## Timing
- Reset values: state=IDLE, starve_cnt=0, and f_ack, d_ack, mem_en, mem_we, busy, mem_addr, mem_wdata, f_rdata, d_rdata all 0.
- Reset is asynchronous. Asserting rst_f mid-ACCESS or mid-DONE drops mem_en and mem_we and clears ack immediately. The aborted transaction is never acknowledged.
- Latency: req is high in cycle 0 (IDLE) and sampled at the end of cycle 0. mem_en is high in cycles 1..MEM_LAT. ack is high in cycle MEM_LAT+1.
- Throughput: one transaction per MEM_LAT+2 cycles under back-to-back requests.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Fetch, MEM_LAT=1: f_req=1 with f_addr=0x0010 in cycle 0, mem_rdata=0x12345678 in cycle 1 -> mem_en=1 and mem_addr=0x0010 in cycle 1; f_ack=1 and f_rdata=0x12345678 in cycle 2; busy low in cycle 3.
- Simultaneous load and fetch, MEM_LAT=1: d_addr=0x0040, f_addr=0x0011, both req high at the same edge -> data served first with d_ack in cycle 2; fetch granted at the cycle-3 IDLE edge; f_ack in cycle 5 with mem_addr=0x0011 in cycle 4.
- Store, MEM_LAT=3: d_we=1, d_addr=0x0020, d_wdata=0xDEADBEEF -> mem_en=mem_we=1 with mem_wdata=0xDEADBEEF for exactly cycles 1-3; d_ack in cycle 4; d_rdata unchanged.
- Starvation, STARVE_MAX=3: d_req and f_req held high continuously -> grant sequence D,D,D,F,D,D,D,F; starve_cnt reads 0,1,2,3,0.
- Reset mid-access, MEM_LAT=4: rst_f low during cycle 2 of ACCESS -> mem_en=0 and busy=0 immediately; no ack follows; after release, a new f_req completes normally in MEM_LAT+2 cycles.
- Input change after grant: f_addr changes from 0x0005 to 0x0099 in cycle 1 -> mem_addr stays 0x0005 for the whole access.
